// File: rtl/enemy_spawn_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | enemy_spawn_scheduler_if                                                   |
// | Frame/game controls in, per-slot mover controls out.                       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface enemy_spawn_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  logic                             startOfFrame;
  logic                             game_run;
  logic                             penalty_mode;
  logic [NUM_SLOTS-1:0]             slot_offscreen;
  logic [NUM_SLOTS-1:0]             slot_restart;
  logic [NUM_SLOTS-1:0]             slot_move_allow;
  logic [2*NUM_SLOTS-1:0]           slot_lane;
  logic [$clog2(NUM_SLOTS+1)-1:0]   active_count;

  modport master (
    output startOfFrame, game_run, penalty_mode, slot_offscreen,
    input  slot_restart, slot_move_allow, slot_lane, active_count
  );

  modport slave (
    input  startOfFrame, game_run, penalty_mode, slot_offscreen,
    output slot_restart, slot_move_allow, slot_lane, active_count
  );
endinterface
`default_nettype wire

// File: rtl/enemy_spawn_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | enemy_spawn_scheduler                                                      |
// | Per-slot cooldown FSMs, round-robin spawn arbiter with frame spacing and   |
// | LFSR lane picker that never repeats the previous lane.                     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module enemy_spawn_scheduler #(
  parameter int          NUM_SLOTS        = 4,
  parameter int          COOLDOWN_FRAMES  = 30,
  parameter int          SPAWN_GAP_FRAMES = 8,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input wire logic               clk,
  input wire logic               reset,
  enemy_spawn_scheduler_if.slave bus
);

  localparam int c_idx_w = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int c_cnt_w = $clog2(COOLDOWN_FRAMES + 1);
  localparam int c_gap_w = $clog2(SPAWN_GAP_FRAMES + 1);
  localparam int c_act_w = $clog2(NUM_SLOTS + 1);

  localparam logic [15:0]        c_lfsr_mask  = 16'hB400;
  localparam logic [c_cnt_w-1:0] c_cooldown   = c_cnt_w'(COOLDOWN_FRAMES);
  localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(1);
  localparam logic [c_gap_w-1:0] c_gap_reload = c_gap_w'(SPAWN_GAP_FRAMES - 1);
  localparam logic [c_idx_w-1:0] c_ptr_init   = c_idx_w'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_READY  = 3'd2,
    S_SPAWN  = 3'd3,
    S_ACTIVE = 3'd4
  } state_t;

  state_t             r_state     [NUM_SLOTS];
  state_t             w_state_nxt [NUM_SLOTS];
  logic [c_cnt_w-1:0] r_cnt       [NUM_SLOTS];
  logic [c_cnt_w-1:0] w_cnt_nxt   [NUM_SLOTS];
  logic [1:0]         r_lane      [NUM_SLOTS];

  logic [c_gap_w-1:0] r_gap;
  logic [c_gap_w-1:0] w_gap_nxt;
  logic [c_idx_w-1:0] r_ptr;
  logic [c_idx_w-1:0] w_grant_idx;
  logic [c_idx_w-1:0] w_scan;
  logic               w_grant;
  logic               w_arb_en;
  logic [15:0]        r_lfsr;
  logic [1:0]         r_last_lane;
  logic [1:0]         w_new_lane;
  logic [c_act_w-1:0] r_active_count;
  logic [c_act_w-1:0] w_active_nxt;

  assign w_arb_en = bus.startOfFrame && bus.game_run && !bus.penalty_mode && (r_gap == '0);

  // Round-robin: first READY slot above the last winner, wrapping.
  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = r_ptr;
    w_scan      = '0;
    if (w_arb_en) begin
      for (int k = 1; k <= NUM_SLOTS; k++) begin
        w_scan = c_idx_w'((int'(r_ptr) + k) % NUM_SLOTS);
        if (!w_grant && (r_state[w_scan] == S_READY)) begin
          w_grant     = 1'b1;
          w_grant_idx = w_scan;
        end
      end
    end
  end

  assign w_new_lane = (r_lfsr[1:0] == r_last_lane) ? (r_lfsr[1:0] + 2'd1) : r_lfsr[1:0];

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if (!bus.game_run) begin
        w_state_nxt[i] = S_IDLE;
      end else if (r_state[i] == S_SPAWN) begin
        // A launched truck always reaches the road, even under penalty.
        w_state_nxt[i] = S_ACTIVE;
      end else if (!bus.penalty_mode) begin
        unique case (r_state[i])
          S_IDLE: begin
            w_state_nxt[i] = S_WAIT;
            w_cnt_nxt[i]   = c_cooldown;
          end
          S_WAIT: begin
            if (bus.startOfFrame) begin
              if (r_cnt[i] == c_cnt_last) w_state_nxt[i] = S_READY;
              else                        w_cnt_nxt[i]   = r_cnt[i] - c_cnt_last;
            end
          end
          S_READY: begin
            if (w_grant && (w_grant_idx == c_idx_w'(i))) w_state_nxt[i] = S_SPAWN;
          end
          S_ACTIVE: begin
            if (bus.slot_offscreen[i]) begin
              w_state_nxt[i] = S_WAIT;
              w_cnt_nxt[i]   = c_cooldown;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_active_nxt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_state_nxt[i] == S_ACTIVE) w_active_nxt = w_active_nxt + c_act_w'(1);
    end
  end

  always_comb begin
    w_gap_nxt = r_gap;
    if (!bus.game_run)                                          w_gap_nxt = '0;
    else if (w_grant)                                           w_gap_nxt = c_gap_reload;
    else if (bus.startOfFrame && !bus.penalty_mode && r_gap != '0) w_gap_nxt = r_gap - c_gap_w'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
        r_lane[i]  <= '0;
      end
      r_gap          <= '0;
      r_ptr          <= c_ptr_init;
      r_lfsr         <= LFSR_SEED;
      r_last_lane    <= '0;
      r_active_count <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      if (w_grant) begin
        r_lane[w_grant_idx] <= w_new_lane;
        r_last_lane         <= w_new_lane;
        r_ptr               <= w_grant_idx;
      end
      r_gap          <= w_gap_nxt;
      r_lfsr         <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_mask : 16'h0000);
      r_active_count <= w_active_nxt;
    end
  end

  // Outputs decode straight from state so an async reset clears them at once.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_out
    assign bus.slot_restart[gi]      = (r_state[gi] == S_SPAWN);
    assign bus.slot_move_allow[gi]   = (r_state[gi] == S_ACTIVE) && !bus.penalty_mode;
    assign bus.slot_lane[2*gi +: 2]  = r_lane[gi];
  end

  assign bus.active_count = r_active_count;

endmodule
`default_nettype wire

// File: tb/tb_enemy_spawn_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_enemy_spawn_scheduler                                                   |
// | Random frame/penalty/offscreen stimulus against a behavioural model.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_enemy_spawn_scheduler;
  localparam int          NS   = 4;
  localparam int          CD   = 30;
  localparam int          GAP  = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  enemy_spawn_scheduler_if #(.NUM_SLOTS(NS)) bus();

  enemy_spawn_scheduler #(
    .NUM_SLOTS(NS), .COOLDOWN_FRAMES(CD), .SPAWN_GAP_FRAMES(GAP), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_COOLDOWN, P_QUEUED, P_LAUNCH, P_ONROAD} phase_t;
  phase_t      m_ph   [NS];
  int          m_cnt  [NS];
  int          m_lane [NS];
  int          m_gap, m_ptr, m_last;
  bit [15:0]   m_lfsr;

  typedef struct packed {
    logic [NS-1:0]   rst;
    logic [NS-1:0]   mv;
    logic [2*NS-1:0] lane;
    logic [2:0]      cnt;
  } exp_t;
  exp_t exp_q[$];

  task automatic m_reset();
    for (int i = 0; i < NS; i++) begin
      m_ph[i] = P_IDLE; m_cnt[i] = 0; m_lane[i] = 0;
    end
    m_gap = 0; m_ptr = NS - 1; m_last = 0; m_lfsr = SEED;
  endtask

  task automatic m_step(bit sof, bit run, bit pen, logic [NS-1:0] off);
    int g = -1;
    int ln;
    if (sof && run && !pen && m_gap == 0) begin
      for (int k = 1; k <= NS; k++) begin
        int s;
        s = (m_ptr + k) % NS;
        if (g < 0 && m_ph[s] == P_QUEUED) g = s;
      end
    end
    if (g >= 0) begin
      ln = int'(m_lfsr % 4);
      if (ln == m_last) ln = (ln + 1) % 4;
      m_lane[g] = ln; m_last = ln; m_ptr = g;
    end
    for (int i = 0; i < NS; i++) begin
      if (!run) m_ph[i] = P_IDLE;
      else if (m_ph[i] == P_LAUNCH) m_ph[i] = P_ONROAD;
      else if (!pen) begin
        case (m_ph[i])
          P_IDLE:     begin m_ph[i] = P_COOLDOWN; m_cnt[i] = CD; end
          P_COOLDOWN: if (sof) begin
                        if (m_cnt[i] == 1) m_ph[i] = P_QUEUED;
                        else m_cnt[i]--;
                      end
          P_QUEUED:   if (g == i) m_ph[i] = P_LAUNCH;
          P_ONROAD:   if (off[i]) begin m_ph[i] = P_COOLDOWN; m_cnt[i] = CD; end
          default: ;
        endcase
      end
    end
    if (!run) m_gap = 0;
    else if (g >= 0) m_gap = GAP - 1;
    else if (sof && !pen && m_gap > 0) m_gap--;
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  initial begin : model
    exp_t e;
    int   n;
    m_reset();
    forever begin
      @(posedge clk);
      if (reset) m_reset();
      else m_step(bus.startOfFrame, bus.game_run, bus.penalty_mode, bus.slot_offscreen);
      #3;
      if (reset) m_reset();
      e = '0; n = 0;
      for (int i = 0; i < NS; i++) begin
        e.rst[i]        = (m_ph[i] == P_LAUNCH);
        e.mv[i]         = (m_ph[i] == P_ONROAD) && !bus.penalty_mode;
        e.lane[2*i +: 2] = 2'(m_lane[i]);
        if (m_ph[i] == P_ONROAD) n++;
      end
      e.cnt = 3'(n);
      exp_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("slot_restart",    bus.slot_restart,    e.rst);
      chk("slot_move_allow", bus.slot_move_allow, e.mv);
      chk("slot_lane",       bus.slot_lane,       e.lane);
      chk("active_count",    bus.active_count,    e.cnt);
    end
  end

  // First-restart frame numbers for the directed schedule check.
  int frame_no = 0;
  bit rec_en   = 0;
  int rec [NS];
  always @(negedge clk) begin
    if (rec_en)
      for (int i = 0; i < NS; i++)
        if (bus.slot_restart[i] && rec[i] < 0) rec[i] = frame_no;
  end

  // ---------------- stimulus ----------------
  task automatic drive_cycle(bit sof, logic [NS-1:0] off, bit run, bit pen);
    @(posedge clk); #2;
    bus.startOfFrame   = sof;
    bus.slot_offscreen = off;
    bus.game_run       = run;
    bus.penalty_mode   = pen;
    if (sof) frame_no++;
  endtask

  function automatic logic [NS-1:0] rand_off();
    logic [NS-1:0] o;
    for (int i = 0; i < NS; i++) o[i] = ($urandom_range(39, 0) == 0);
    return o;
  endfunction

  task automatic sched_check(string tag);
    for (int i = 0; i < NS; i++) rec[i] = -1;
    drive_cycle(0, '0, 1, 0);
    frame_no = 0;
    rec_en   = 1;
    for (int f = 0; f < 60; f++) begin
      drive_cycle(1, '0, 1, 0);
      repeat (3) drive_cycle(0, '0, 1, 0);
    end
    rec_en = 0;
    for (int i = 0; i < NS; i++)
      chk($sformatf("%s_first_spawn_frame_slot%0d", tag, i), rec[i], CD + 1 + i * GAP);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    bit run, pen;
    int pen_left, drop_left;
    bit found;
    bus.startOfFrame = 0; bus.game_run = 0; bus.penalty_mode = 0; bus.slot_offscreen = '0;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    for (int f = 0; f < 3; f++) begin
      drive_cycle(1, rand_off(), 0, 0);
      repeat (3) drive_cycle(0, rand_off(), 0, 0);
    end

    sched_check("run1");

    // Random play: offscreen events, penalty windows, occasional round drops.
    run = 1; pen = 0; pen_left = 0; drop_left = 0;
    for (int f = 0; f < 250; f++) begin
      int len;
      len = $urandom_range(6, 3);
      if (pen_left > 0) begin
        pen_left--;
        if (pen_left == 0) pen = 0;
      end else if ($urandom_range(99, 0) < 4) begin
        pen = 1; pen_left = $urandom_range(20, 1);
      end
      if (drop_left > 0) begin
        drop_left--;
        if (drop_left == 0) run = 1;
      end else if ($urandom_range(99, 0) < 2) begin
        run = 0; drop_left = $urandom_range(3, 1);
      end
      drive_cycle(1, rand_off(), run, pen);
      for (int c = 1; c < len; c++) drive_cycle(0, rand_off(), run, pen);
    end

    // Round drop then restart, then async reset while a slot is spawning.
    repeat (2) drive_cycle(0, '0, 0, 0);
    found = 0;
    for (int c = 0; c < 3000 && !found; c++) begin
      drive_cycle((c % 4) == 0, '0, 1, 0);
      @(negedge clk);
      if (bus.slot_restart != '0) found = 1;
    end
    chk("spawn_seen_before_reset", found, 1);
    if (found) begin
      #1 reset = 1;
      #1;
      chk("async_reset_restart",      bus.slot_restart,    0);
      chk("async_reset_move_allow",   bus.slot_move_allow, 0);
      chk("async_reset_lane",         bus.slot_lane,       0);
      chk("async_reset_active_count", bus.active_count,    0);
    end
    repeat (2) drive_cycle(0, '0, 0, 0);
    @(posedge clk); #2 reset = 0;
    for (int f = 0; f < 5; f++) begin
      drive_cycle(1, rand_off(), 0, 0);
      repeat (3) drive_cycle(0, rand_off(), 0, 0);
    end

    sched_check("run2");

    repeat (3) drive_cycle(0, '0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
